// File: rtl/out_arbiter_if.sv
// FIFO-side and output-side handshake bundle for the two-source output arbiter.
// The master modport is the arbiter; the slave modport is the FIFOs plus the downstream sink.
interface out_arbiter_if;
    localparam int unsigned DW = 6;

    logic          empty_D0;
    logic          empty_D1;
    logic [DW-1:0] data_D0;
    logic [DW-1:0] data_D1;
    logic          pop_D0;
    logic          pop_D1;
    logic          ready_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          dest_out;

    modport master (
        input  empty_D0, empty_D1, data_D0, data_D1, ready_out,
        output pop_D0, pop_D1, valid_out, data_out, dest_out
    );

    modport slave (
        output empty_D0, empty_D1, data_D0, data_D1, ready_out,
        input  pop_D0, pop_D1, valid_out, data_out, dest_out
    );
endinterface

// File: rtl/out_arbiter.sv
// Round-robin merge of two 6-bit FIFOs into a 3-entry output buffer.
// Pops are throttled so that buffered plus in-flight words never exceed the buffer depth.
module out_arbiter (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               init,
    out_arbiter_if.master      bus,
    output logic [4:0]         count_D0,
    output logic [4:0]         count_D1,
    output logic               idle_out
);
    localparam int unsigned DW    = 6;
    localparam int unsigned CW    = 5;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned OW    = 2;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Entry layout: {source, data}; entries at or beyond occupancy are kept at zero.
    logic [DW:0]   buf_q [DEPTH];
    logic [DW:0]   buf_d [DEPTH];
    logic [OW-1:0] occ_q, occ_d;
    logic          valid_q, valid_d;
    logic          infl_q, infl_d;
    logic          infl_src_q, infl_src_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic          can_pop_c;
    logic          pop0_c, pop1_c;
    logic          xfer_c;
    logic [OW-1:0] wr_idx_c;
    logic [DW-1:0] cap_data_c;

    // Pop issue and round-robin pointer update.
    always_comb begin
        pop0_c    = 1'b0;
        pop1_c    = 1'b0;
        rr_d      = rr_q;
        can_pop_c = reset_L && !init && ((3'(occ_q) + 3'(infl_q)) <= 3'd2);
        if (can_pop_c) begin
            if (!bus.empty_D0 && !bus.empty_D1) begin
                pop0_c = !rr_q;
                pop1_c = rr_q;
                rr_d   = !rr_q;
            end else if (!bus.empty_D0) begin
                pop0_c = 1'b1;
                rr_d   = 1'b1;
            end else if (!bus.empty_D1) begin
                pop1_c = 1'b1;
                rr_d   = 1'b0;
            end
        end
    end

    // Buffer shift on transfer, tail write on capture, delivery counters.
    always_comb begin
        buf_d      = buf_q;
        xfer_c     = valid_q && bus.ready_out;
        cap_data_c = infl_src_q ? bus.data_D1 : bus.data_D0;
        wr_idx_c   = occ_q - OW'(xfer_c);
        if (xfer_c) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            buf_d[2] = '0;
        end
        if (infl_q) begin
            buf_d[wr_idx_c] = {infl_src_q, cap_data_c};
        end
        occ_d      = occ_q + OW'(infl_q) - OW'(xfer_c);
        valid_d    = (occ_d != '0);
        infl_d     = pop0_c || pop1_c;
        infl_src_d = pop1_c;

        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (init) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (xfer_c) begin
            if (!buf_q[0][DW] && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CW'(1);
            if ( buf_q[0][DW] && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
            occ_q      <= '0;
            valid_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_src_q <= 1'b0;
            rr_q       <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= buf_d[i];
            occ_q      <= occ_d;
            valid_q    <= valid_d;
            infl_q     <= infl_d;
            infl_src_q <= infl_src_d;
            rr_q       <= rr_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.pop_D0    = pop0_c;
    assign bus.pop_D1    = pop1_c;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = buf_q[0][DW-1:0];
    assign bus.dest_out  = buf_q[0][DW];
    assign count_D0      = cnt0_q;
    assign count_D1      = cnt1_q;
    assign idle_out      = (occ_q == '0) && !infl_q && bus.empty_D0 && bus.empty_D1;
endmodule

// File: tb/tb_out_arbiter.sv
// Directed bench for out_arbiter: behavioural FIFO sources, a sink monitor and per-scenario tasks.
module tb_out_arbiter;
    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [4:0] count_D0;
    logic [4:0] count_D1;
    logic       idle_out;

    out_arbiter_if bus ();

    out_arbiter dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .init     (init),
        .bus      (bus),
        .count_D0 (count_D0),
        .count_D1 (count_D1),
        .idle_out (idle_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_both  = 0;
    int err_empty = 0;

    logic [5:0] q0 [$];
    logic [5:0] q1 [$];
    bit         pop_log  [$];
    logic [6:0] out_q    [$];
    int         xfer_cyc [$];

    // FIFO models (read data one cycle after pop) and downstream sink monitor.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.pop_D0 && bus.pop_D1) err_both = err_both + 1;
        if ((bus.pop_D0 && bus.empty_D0) || (bus.pop_D1 && bus.empty_D1)) err_empty = err_empty + 1;
        if (bus.pop_D0) begin
            pop_log.push_back(1'b0);
            if (q0.size() > 0) bus.data_D0 <= q0.pop_front();
        end
        if (bus.pop_D1) begin
            pop_log.push_back(1'b1);
            if (q1.size() > 0) bus.data_D1 <= q1.pop_front();
        end
        bus.empty_D0 <= (q0.size() == 0);
        bus.empty_D1 <= (q1.size() == 0);
        if (bus.valid_out && bus.ready_out) begin
            out_q.push_back({bus.dest_out, bus.data_out});
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        reset_L = 1'b0;
        init    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        pop_log.delete();
        out_q.delete();
        xfer_cyc.delete();
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (out_q.size() >= n) break;
        end
        total++;
        if (out_q.size() < n) begin
            bad++;
            $display("FAIL %s_timeout got=%0d words exp=%0d", tag, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        init    = 1'b0;
        bus.ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.data_out !== 6'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.data_out); end
        total++; if (bus.dest_out !== 1'b0) begin bad++; $display("FAIL rst_dest got=%b exp=0", bus.dest_out); end
        total++; if (count_D0 !== 5'd0 || count_D1 !== 5'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", count_D0, count_D1); end
        total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b00) begin bad++; $display("FAIL rst_pops got=%b exp=00", {bus.pop_D0, bus.pop_D1}); end
        reset_L = 1'b1;
        #1;
        total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle_out); end
    endtask

    task automatic test_round_robin();
        logic [6:0] exp [$];
        bit ok;
        do_reset();
        bus.ready_out = 1'b1;
        q0.push_back(6'h0D); q0.push_back(6'h03); q0.push_back(6'h0C); q0.push_back(6'h09);
        q1.push_back(6'h1B); q1.push_back(6'h11); q1.push_back(6'h1A); q1.push_back(6'h19);
        exp.push_back({1'b0, 6'h0D}); exp.push_back({1'b1, 6'h1B});
        exp.push_back({1'b0, 6'h03}); exp.push_back({1'b1, 6'h11});
        exp.push_back({1'b0, 6'h0C}); exp.push_back({1'b1, 6'h1A});
        exp.push_back({1'b0, 6'h09}); exp.push_back({1'b1, 6'h19});
        wait_out(8, 40, "rr");
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= out_q.size() || out_q[i] !== exp[i]) begin
                bad++; $display("FAIL rr_word[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 7'h7F, exp[i]);
            end
        end
        ok = (pop_log.size() == 8);
        for (int i = 0; i < pop_log.size(); i++) if (pop_log[i] != bit'(i % 2)) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rr_pop_order got=%0d pops exp=8 alternating from D0", pop_log.size()); end
        ok = (xfer_cyc.size() == 8);
        for (int i = 1; i < xfer_cyc.size(); i++) if (xfer_cyc[i] != xfer_cyc[i-1] + 1) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rr_one_per_cycle got=gaps exp=consecutive"); end
        total++; if (count_D0 !== 5'd4 || count_D1 !== 5'd4) begin bad++; $display("FAIL rr_counts got=%0d/%0d exp=4/4", count_D0, count_D1); end
        total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL rr_idle got=%b exp=1", idle_out); end
    endtask

    task automatic test_d1_only();
        logic [6:0] exp [$];
        bit ok;
        do_reset();
        bus.ready_out = 1'b1;
        q1.push_back(6'h3B); q1.push_back(6'h3D); q1.push_back(6'h1F);
        exp.push_back({1'b1, 6'h3B}); exp.push_back({1'b1, 6'h3D}); exp.push_back({1'b1, 6'h1F});
        wait_out(3, 30, "d1");
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= out_q.size() || out_q[i] !== exp[i]) begin
                bad++; $display("FAIL d1_word[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 7'h7F, exp[i]);
            end
        end
        ok = (pop_log.size() == 3);
        for (int i = 0; i < pop_log.size(); i++) if (pop_log[i] != 1'b1) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL d1_pops got=%0d pops exp=3 on D1 only", pop_log.size()); end
        ok = (xfer_cyc.size() == 3) && (xfer_cyc[1] == xfer_cyc[0] + 1) && (xfer_cyc[2] == xfer_cyc[1] + 1);
        total++; if (!ok) begin bad++; $display("FAIL d1_consecutive got=gaps exp=consecutive"); end
        total++; if (count_D0 !== 5'd0 || count_D1 !== 5'd3) begin bad++; $display("FAIL d1_counts got=%0d/%0d exp=0/3", count_D0, count_D1); end
    endtask

    task automatic test_backpressure();
        logic [6:0] exp [$];
        do_reset();
        bus.ready_out = 1'b0;
        q0.push_back(6'h01); q0.push_back(6'h02); q0.push_back(6'h03); q0.push_back(6'h04);
        q1.push_back(6'h21); q1.push_back(6'h22); q1.push_back(6'h23); q1.push_back(6'h24);
        repeat (8) @(posedge clk);
        #1;
        total++; if (pop_log.size() != 3) begin bad++; $display("FAIL bp_pop_count got=%0d exp=3", pop_log.size()); end
        total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b00) begin bad++; $display("FAIL bp_pops_stopped got=%b exp=00", {bus.pop_D0, bus.pop_D1}); end
        total++; if (idle_out !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", idle_out); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.valid_out !== 1'b1 || {bus.dest_out, bus.data_out} !== {1'b0, 6'h01}) begin
                bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/01", i, bus.valid_out, {bus.dest_out, bus.data_out});
            end
            @(posedge clk);
            #1;
        end
        bus.ready_out = 1'b1;
        exp.push_back({1'b0, 6'h01}); exp.push_back({1'b1, 6'h21});
        exp.push_back({1'b0, 6'h02}); exp.push_back({1'b1, 6'h22});
        exp.push_back({1'b0, 6'h03}); exp.push_back({1'b1, 6'h23});
        exp.push_back({1'b0, 6'h04}); exp.push_back({1'b1, 6'h24});
        wait_out(8, 40, "bp");
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_q.size() != 8) begin bad++; $display("FAIL bp_word_count got=%0d exp=8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= out_q.size() || out_q[i] !== exp[i]) begin
                bad++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 7'h7F, exp[i]);
            end
        end
        total++; if (count_D0 !== 5'd4 || count_D1 !== 5'd4) begin bad++; $display("FAIL bp_counts got=%0d/%0d exp=4/4", count_D0, count_D1); end
    endtask

    task automatic test_init();
        logic [6:0] exp [$];
        do_reset();
        bus.ready_out = 1'b1;
        q0.push_back(6'h10); q0.push_back(6'h11); q0.push_back(6'h12); q0.push_back(6'h13);
        q1.push_back(6'h30); q1.push_back(6'h31); q1.push_back(6'h32); q1.push_back(6'h33);
        wait_out(3, 30, "init_pre");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            init = 1'b1;
            #1;
            total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b00) begin bad++; $display("FAIL init_no_pop[%0d] got=%b exp=00", i, {bus.pop_D0, bus.pop_D1}); end
        end
        @(posedge clk);
        #1;
        init = 1'b0;
        #1;
        total++; if (count_D0 !== 5'd0 || count_D1 !== 5'd0) begin bad++; $display("FAIL init_counts_clear got=%0d/%0d exp=0/0", count_D0, count_D1); end
        total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b01) begin bad++; $display("FAIL init_resume got=%b exp=01", {bus.pop_D0, bus.pop_D1}); end
        exp.push_back({1'b0, 6'h10}); exp.push_back({1'b1, 6'h30});
        exp.push_back({1'b0, 6'h11}); exp.push_back({1'b1, 6'h31});
        exp.push_back({1'b0, 6'h12}); exp.push_back({1'b1, 6'h32});
        exp.push_back({1'b0, 6'h13}); exp.push_back({1'b1, 6'h33});
        wait_out(8, 40, "init_post");
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= out_q.size() || out_q[i] !== exp[i]) begin
                bad++; $display("FAIL init_word[%0d] got=%h exp=%h", i, (i < out_q.size()) ? out_q[i] : 7'h7F, exp[i]);
            end
        end
        total++; if (count_D0 !== 5'd1 || count_D1 !== 5'd2) begin bad++; $display("FAIL init_final_counts got=%0d/%0d exp=1/2", count_D0, count_D1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ready_out = 1'b1;
        q0.push_back(6'h2A); q0.push_back(6'h2B);
        q1.push_back(6'h3C);
        @(posedge clk);
        #1;
        total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b10) begin bad++; $display("FAIL rmid_first_pop got=%b exp=10", {bus.pop_D0, bus.pop_D1}); end
        @(posedge clk);
        #1;
        reset_L = 1'b0;
        #1;
        total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b00) begin bad++; $display("FAIL rmid_pop_in_reset got=%b exp=00", {bus.pop_D0, bus.pop_D1}); end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        #1;
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.valid_out); end
        total++; if (count_D0 !== 5'd0 || count_D1 !== 5'd0) begin bad++; $display("FAIL rmid_counts got=%0d/%0d exp=0/0", count_D0, count_D1); end
        total++; if ({bus.pop_D0, bus.pop_D1} !== 2'b10) begin bad++; $display("FAIL rmid_rr_reset got=%b exp=10", {bus.pop_D0, bus.pop_D1}); end
        wait_out(2, 20, "rmid");
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_q.size() != 2) begin bad++; $display("FAIL rmid_word_count got=%0d exp=2", out_q.size()); end
        total++; if (out_q.size() < 2 || out_q[0] !== {1'b0, 6'h2B} || out_q[1] !== {1'b1, 6'h3C}) begin
            bad++; $display("FAIL rmid_words got=%h,%h exp=2b,7c",
                            (out_q.size() > 0) ? out_q[0] : 7'h7F, (out_q.size() > 1) ? out_q[1] : 7'h7F);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.ready_out = 1'b1;
        for (int i = 0; i < 40; i++) q0.push_back(6'(i));
        wait_out(40, 120, "sat");
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_q.size() != 40 || out_q[39] !== {1'b0, 6'd39}) begin
            bad++; $display("FAIL sat_stream got=%0d words exp=40 ending 27", out_q.size());
        end
        total++; if (count_D0 !== 5'd31) begin bad++; $display("FAIL sat_count_D0 got=%0d exp=31", count_D0); end
        total++; if (count_D1 !== 5'd0) begin bad++; $display("FAIL sat_count_D1 got=%0d exp=0", count_D1); end
    endtask

    task automatic test_protocol();
        total++; if (err_both != 0) begin bad++; $display("FAIL proto_dual_pop got=%0d exp=0", err_both); end
        total++; if (err_empty != 0) begin bad++; $display("FAIL proto_pop_empty got=%0d exp=0", err_empty); end
    endtask

    initial begin
        reset_L = 1'b0;
        init    = 1'b0;
        bus.ready_out = 1'b0;
        test_reset();
        test_round_robin();
        test_d1_only();
        test_backpressure();
        test_init();
        test_reset_mid();
        test_saturate();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_arbiter.md
OUT_ARBITER -- requirements
Module: out_arbiter

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: reset_L  input  1  reset; synchronous, active-low.
REQ-003 SHALL expose: init  input  1  hold request; while high no new pops are issued and counters clear.
REQ-004 SHALL expose: empty_D0  input  1  D0 FIFO empty flag.
REQ-005 SHALL expose: empty_D1  input  1  D1 FIFO empty flag.
REQ-006 SHALL expose: data_D0  input  6  D0 FIFO read data; valid in the cycle after pop_D0.
REQ-007 SHALL expose: data_D1  input  6  D1 FIFO read data; valid in the cycle after pop_D1.
REQ-008 SHALL expose: pop_D0  output  1  read strobe to D0 FIFO.
REQ-009 SHALL expose: pop_D1  output  1  read strobe to D1 FIFO.
REQ-010 SHALL expose: ready_out  input  1  downstream accepts the word this cycle.
REQ-011 SHALL expose: valid_out  output  1  data_out/dest_out hold a word.
REQ-012 SHALL expose: data_out  output  6  merged output word.
REQ-013 SHALL expose: dest_out  output  1  source of data_out (0 = D0, 1 = D1).
REQ-014 SHALL expose: count_D0  output  5  words from D0 delivered since reset/init.
REQ-015 SHALL expose: count_D1  output  5  words from D1 delivered since reset/init.
REQ-016 SHALL expose: idle_out  output  1  no data anywhere in the block and both FIFOs empty.

Function
REQ-017 SHALL contain a 3-entry output buffer (6-bit data + 1-bit source per entry, FIFO order); valid_out = occupancy > 0; data_out/dest_out = head entry.
REQ-018 SHALL treat a transfer as valid_out & ready_out in the same cycle; head is removed at that clock edge.
REQ-019 SHALL track in-flight pops (issued in cycle N, data captured at the edge ending cycle N+1); inflight is 0 or 1.
REQ-020 SHALL issue a pop in cycle N only when init=0, reset_L=1, and occupancy + inflight <= 2 (registered values); sustains one word per cycle when ready_out stays high.
REQ-021 SHALL never assert pop_D0 and pop_D1 together and never pop a FIFO whose empty flag is high.
REQ-022 SHALL arbitrate round-robin via pointer rr: both non-empty -> pop D(rr), then rr flips; only one non-empty -> pop it, rr set to the other; none -> no pop, rr unchanged.
REQ-023 SHALL write captured data into the buffer tail with its source bit; a simultaneous capture and transfer leaves occupancy unchanged.
REQ-024 SHALL increment count_D0/count_D1 on each transfer with dest_out = 0/1, saturating at 31 (no wrap).
REQ-025 SHALL, while init=1, clear both counters and block pops; an already in-flight word is still captured; the buffer keeps draining.
REQ-026 SHALL drive idle_out = 1 iff occupancy = 0, inflight = 0, empty_D0 = 1, empty_D1 = 1 (combinational on registered state and flags).
REQ-027 SHALL keep data_out/dest_out stable while valid_out=1 and ready_out=0.

Reset
REQ-028 SHALL, with reset_L=0 at a rising edge, clear occupancy, inflight, rr (to 0) and both counters; data_out = 0, dest_out = 0, valid_out = 0.
REQ-029 SHALL hold pop_D0 = pop_D1 = 0 while reset_L = 0.
REQ-030 SHALL discard data returning in the cycle after reset for a pop issued before reset (reset mid-operation).

Verification
REQ-031 SHALL cover: D0 holds 0x0D,0x03,0x0C,0x09, D1 holds 0x1B,0x11,0x1A,0x19, ready_out=1 -> pops alternate D0,D1 starting D0; data_out order 0x0D,0x1B,0x03,0x11,0x0C,0x1A,0x09,0x19, one per cycle; counts end 4/4; idle_out=1.
REQ-032 SHALL cover: only D1 holds 0x3B,0x3D,0x1F -> pop_D1 only, three consecutive words, dest_out=1, count_D1=3, count_D0=0.
REQ-033 SHALL cover: ready_out=0 with both FIFOs full -> exactly 3 pops issued then pops stop; valid_out=1; data_out held; release ready_out -> no loss or duplication.
REQ-034 SHALL cover: init raised for 3 cycles mid-stream -> no pops during init, in-flight word delivered, counters read 0 after init, arbitration resumes.
REQ-035 SHALL cover: reset_L pulsed low the cycle after a pop -> returned word dropped, valid_out=0, counters 0, rr=0 next cycle.
REQ-036 SHALL cover: 40 D0 words delivered -> count_D0 saturates at 31.
